// File: rtl/branch_predict_ctrl.sv
// Static branch predictor front end: predicts J/B targets, queues predictions, redirects on mispredict.
// States: RUN = fetching | JWAIT = stalled on unresolved jalr | FLUSH = one-cycle redirect bubble
module branch_predict_ctrl #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        inst_jal_i,
  input  logic        inst_jalr_i,
  input  logic        inst_bxx_i,
  input  logic [31:0] jump_and_branch_imm_i,
  input  logic        ex_resolve_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  output logic [31:0] pc_o,
  output logic        fetch_req_o,
  output logic        accept_o,
  output logic        flush_o,
  output logic        hold_o,
  output logic [3:0]  q_count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RUN, JWAIT, FLUSH} state_t;

  state_t          state_q;
  logic [31:0]     pc_q;
  logic [3:0]      count_q;
  logic [PW-1:0]   head_q, tail_q;
  logic            flush_q;
  logic            q_jalr_q [DEPTH];
  logic            q_pred_q [DEPTH];
  logic [31:0]     q_fall_q [DEPTH];

  logic            full, pop, mispredict, do_push;
  logic            push_jalr, push_pred;
  logic [31:0]     redirect_addr, seq_addr, tgt_addr, accept_pc;
  logic [3:0]      count_d;

  always_comb begin
    full          = (count_q == 4'(DEPTH));
    fetch_req_o   = (state_q == RUN) && !full;
    accept_o      = inst_valid_i && fetch_req_o;
    hold_o        = full;
    pop           = ex_resolve_i && (count_q != 4'd0);
    mispredict    = pop && (q_jalr_q[head_q] || (ex_taken_i != q_pred_q[head_q]));
    redirect_addr = ex_taken_i ? ex_target_i : q_fall_q[head_q];
    seq_addr      = inst_addr_i + 32'd4;
    tgt_addr      = inst_addr_i + jump_and_branch_imm_i;
    // jal wins over jalr over bxx if pre-decode ever flags more than one
    push_jalr     = !inst_jal_i && inst_jalr_i;
    push_pred     = inst_jal_i || (!inst_jalr_i && inst_bxx_i && jump_and_branch_imm_i[31]);
    do_push       = accept_o && !mispredict && (inst_jal_i || inst_jalr_i || inst_bxx_i);
    accept_pc     = push_pred ? tgt_addr : seq_addr;
    count_d       = count_q + {3'b000, do_push} - {3'b000, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_ADDR;
      count_q <= 4'd0;
      head_q  <= '0;
      tail_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= mispredict;
      if (mispredict) begin
        pc_q    <= redirect_addr;
        count_q <= 4'd0;
        head_q  <= '0;
        tail_q  <= '0;
        state_q <= FLUSH;
      end else begin
        if (pop) head_q <= head_q + 1'b1;
        if (do_push) begin
          q_jalr_q[tail_q] <= push_jalr;
          q_pred_q[tail_q] <= push_pred;
          q_fall_q[tail_q] <= seq_addr;
          tail_q           <= tail_q + 1'b1;
        end
        count_q <= count_d;
        if (accept_o) pc_q <= accept_pc;
        case (state_q)
          RUN:     if (accept_o && push_jalr) state_q <= JWAIT;
          FLUSH:   state_q <= RUN;
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign pc_o      = pc_q;
  assign flush_o   = flush_q;
  assign q_count_o = count_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: each scenario task drives stimulus and checks its own results.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_valid_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic        inst_jal_i = 1'b0, inst_jalr_i = 1'b0, inst_bxx_i = 1'b0;
  logic [31:0] jump_and_branch_imm_i = '0;
  logic        ex_resolve_i = 1'b0, ex_taken_i = 1'b0;
  logic [31:0] ex_target_i = '0;
  logic [31:0] pc_o;
  logic        fetch_req_o, accept_o, flush_o, hold_o;
  logic [3:0]  q_count_o;

  int vectors = 0;
  int miscompares = 0;

  branch_predict_ctrl #(.DEPTH(4), .RESET_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
    .inst_jal_i(inst_jal_i), .inst_jalr_i(inst_jalr_i), .inst_bxx_i(inst_bxx_i),
    .jump_and_branch_imm_i(jump_and_branch_imm_i),
    .ex_resolve_i(ex_resolve_i), .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .pc_o(pc_o), .fetch_req_o(fetch_req_o), .accept_o(accept_o),
    .flush_o(flush_o), .hold_o(hold_o), .q_count_o(q_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 none, 1 jal, 2 jalr, 3 bxx, 4 other
  task automatic set_inst(input int kind, input logic [31:0] addr, input logic [31:0] imm);
    inst_valid_i          = (kind != 0);
    inst_addr_i           = addr;
    inst_jal_i            = (kind == 1);
    inst_jalr_i           = (kind == 2);
    inst_bxx_i            = (kind == 3);
    jump_and_branch_imm_i = imm;
    #1;
  endtask

  task automatic set_res(input logic r, input logic t, input logic [31:0] tgt);
    ex_resolve_i = r;
    ex_taken_i   = t;
    ex_target_i  = tgt;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h want %h", pc_o, 32'h0); end
    vectors++; if (q_count_o !== 4'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", q_count_o); end
    vectors++; if (flush_o !== 1'b0) begin miscompares++; $display("FAIL rst_flush got %b want 0", flush_o); end
    vectors++; if (hold_o !== 1'b0) begin miscompares++; $display("FAIL rst_hold got %b want 0", hold_o); end
    vectors++; if (fetch_req_o !== 1'b1) begin miscompares++; $display("FAIL rst_fetch got %b want 1", fetch_req_o); end
  endtask

  task automatic test_backward_branch();
    set_inst(3, 32'h100, 32'hFFFF_FFF0);
    vectors++; if (accept_o !== 1'b1) begin miscompares++; $display("FAIL bb_accept got %b want 1", accept_o); end
    tick(); set_inst(0, 0, 0);
    vectors++; if (pc_o !== 32'h0F0) begin miscompares++; $display("FAIL bb_pc got %h want %h", pc_o, 32'h0F0); end
    vectors++; if (q_count_o !== 4'd1) begin miscompares++; $display("FAIL bb_count got %0d want 1", q_count_o); end
    set_res(1, 1, 32'h0F0); tick(); set_res(0, 0, 0);
    vectors++; if (flush_o !== 1'b0) begin miscompares++; $display("FAIL bb_noflush got %b want 0", flush_o); end
    vectors++; if (q_count_o !== 4'd0) begin miscompares++; $display("FAIL bb_pop got %0d want 0", q_count_o); end
    vectors++; if (pc_o !== 32'h0F0) begin miscompares++; $display("FAIL bb_pc_hold got %h want %h", pc_o, 32'h0F0); end
  endtask

  task automatic test_forward_mispredict();
    set_inst(3, 32'h200, 32'h40); tick(); set_inst(0, 0, 0);
    vectors++; if (pc_o !== 32'h204) begin miscompares++; $display("FAIL fm_pc got %h want %h", pc_o, 32'h204); end
    set_res(1, 1, 32'h240); tick(); set_res(0, 0, 0);
    vectors++; if (pc_o !== 32'h240) begin miscompares++; $display("FAIL fm_redirect got %h want %h", pc_o, 32'h240); end
    vectors++; if (flush_o !== 1'b1) begin miscompares++; $display("FAIL fm_flush got %b want 1", flush_o); end
    vectors++; if (q_count_o !== 4'd0) begin miscompares++; $display("FAIL fm_count got %0d want 0", q_count_o); end
    vectors++; if (fetch_req_o !== 1'b0) begin miscompares++; $display("FAIL fm_flush_state got %b want 0", fetch_req_o); end
    tick();
    vectors++; if (flush_o !== 1'b0) begin miscompares++; $display("FAIL fm_flush_pulse got %b want 0", flush_o); end
    vectors++; if (fetch_req_o !== 1'b1) begin miscompares++; $display("FAIL fm_run got %b want 1", fetch_req_o); end
  endtask

  task automatic test_jalr();
    set_inst(3, 32'h2FC, 32'h40); tick();
    set_inst(2, 32'h300, 32'h0); tick();
    set_inst(1, 32'h900, 32'h10);
    vectors++; if (pc_o !== 32'h304) begin miscompares++; $display("FAIL jr_pc got %h want %h", pc_o, 32'h304); end
    vectors++; if (fetch_req_o !== 1'b0) begin miscompares++; $display("FAIL jr_fetch got %b want 0", fetch_req_o); end
    vectors++; if (accept_o !== 1'b0) begin miscompares++; $display("FAIL jr_accept got %b want 0", accept_o); end
    vectors++; if (q_count_o !== 4'd2) begin miscompares++; $display("FAIL jr_count got %0d want 2", q_count_o); end
    set_inst(0, 0, 0);
    set_res(1, 0, 32'h0); tick();
    vectors++; if (flush_o !== 1'b0) begin miscompares++; $display("FAIL jr_bxx_pop got %b want 0", flush_o); end
    vectors++; if (fetch_req_o !== 1'b0) begin miscompares++; $display("FAIL jr_still_wait got %b want 0", fetch_req_o); end
    set_res(1, 1, 32'h1000); tick(); set_res(0, 0, 0);
    vectors++; if (pc_o !== 32'h1000) begin miscompares++; $display("FAIL jr_target got %h want %h", pc_o, 32'h1000); end
    vectors++; if (flush_o !== 1'b1) begin miscompares++; $display("FAIL jr_flush got %b want 1", flush_o); end
    vectors++; if (fetch_req_o !== 1'b0) begin miscompares++; $display("FAIL jr_flush_state got %b want 0", fetch_req_o); end
    tick();
    vectors++; if (fetch_req_o !== 1'b1 || flush_o !== 1'b0) begin miscompares++; $display("FAIL jr_run got fetch=%b flush=%b want 1/0", fetch_req_o, flush_o); end
  endtask

  task automatic test_full_queue();
    for (int i = 0; i < 4; i++) begin
      set_inst(1, 32'(i * 16), 32'h10); tick();
    end
    set_inst(1, 32'h40, 32'h10);
    vectors++; if (hold_o !== 1'b1) begin miscompares++; $display("FAIL fq_hold got %b want 1", hold_o); end
    vectors++; if (accept_o !== 1'b0) begin miscompares++; $display("FAIL fq_accept got %b want 0", accept_o); end
    vectors++; if (pc_o !== 32'h40) begin miscompares++; $display("FAIL fq_pc got %h want %h", pc_o, 32'h40); end
    set_res(1, 1, 32'h10); tick(); set_res(0, 0, 0);
    vectors++; if (q_count_o !== 4'd3 || flush_o !== 1'b0) begin miscompares++; $display("FAIL fq_pop got count=%0d flush=%b want 3/0", q_count_o, flush_o); end
    vectors++; if (accept_o !== 1'b1) begin miscompares++; $display("FAIL fq_accept_next got %b want 1", accept_o); end
    tick(); set_inst(0, 0, 0);
    vectors++; if (q_count_o !== 4'd4) begin miscompares++; $display("FAIL fq_count got %0d want 4", q_count_o); end
    vectors++; if (pc_o !== 32'h50) begin miscompares++; $display("FAIL fq_pc5 got %h want %h", pc_o, 32'h50); end
    // remaining falls in order: 0x14, 0x24, 0x34, 0x44
    for (int i = 0; i < 3; i++) begin
      set_res(1, 1, 32'h0); tick();
    end
    set_res(1, 0, 32'h0); tick(); set_res(0, 0, 0);
    vectors++; if (pc_o !== 32'h44 || flush_o !== 1'b1) begin miscompares++; $display("FAIL fq_order got pc=%h flush=%b want 00000044/1", pc_o, flush_o); end
    tick();
  endtask

  task automatic test_simultaneous();
    set_inst(3, 32'h500, 32'h20); tick();
    set_inst(1, 32'h600, 32'h100); set_res(1, 1, 32'h520);
    vectors++; if (accept_o !== 1'b1) begin miscompares++; $display("FAIL sim_accept got %b want 1", accept_o); end
    tick(); set_inst(0, 0, 0); set_res(0, 0, 0);
    vectors++; if (pc_o !== 32'h520) begin miscompares++; $display("FAIL sim_pc got %h want %h", pc_o, 32'h520); end
    vectors++; if (q_count_o !== 4'd0 || flush_o !== 1'b1) begin miscompares++; $display("FAIL sim_drop got count=%0d flush=%b want 0/1", q_count_o, flush_o); end
    tick();
    set_inst(1, 32'hFFFF_FFF8, 32'h10); tick(); set_inst(0, 0, 0);
    vectors++; if (pc_o !== 32'h0000_0008) begin miscompares++; $display("FAIL wrap_pc got %h want %h", pc_o, 32'h8); end
    set_res(1, 1, 32'h8); tick(); set_res(0, 0, 0);
    vectors++; if (q_count_o !== 4'd0) begin miscompares++; $display("FAIL wrap_pop got %0d want 0", q_count_o); end
  endtask

  task automatic test_empty_and_other();
    set_res(1, 1, 32'hDEAD_0000); tick(); set_res(0, 0, 0);
    vectors++; if (pc_o !== 32'h8 || flush_o !== 1'b0 || q_count_o !== 4'd0) begin miscompares++; $display("FAIL empty_res got pc=%h flush=%b count=%0d want 00000008/0/0", pc_o, flush_o, q_count_o); end
    set_inst(4, 32'h700, 32'h0); tick(); set_inst(0, 0, 0);
    vectors++; if (pc_o !== 32'h704 || q_count_o !== 4'd0) begin miscompares++; $display("FAIL other got pc=%h count=%0d want 00000704/0", pc_o, q_count_o); end
    tick();
    vectors++; if (pc_o !== 32'h704) begin miscompares++; $display("FAIL idle_hold got %h want %h", pc_o, 32'h704); end
  endtask

  task automatic test_reset_mid();
    set_inst(3, 32'h800, 32'h8); tick();
    set_inst(3, 32'h804, 32'h8); tick();
    set_inst(2, 32'h808, 32'h0); tick(); set_inst(0, 0, 0);
    vectors++; if (q_count_o !== 4'd3 || fetch_req_o !== 1'b0) begin miscompares++; $display("FAIL rm_setup got count=%0d fetch=%b want 3/0", q_count_o, fetch_req_o); end
    rst = 1'b1; set_res(1, 1, 32'h1234); tick(); rst = 1'b0; set_res(0, 0, 0);
    vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL rm_pc got %h want %h", pc_o, 32'h0); end
    vectors++; if (q_count_o !== 4'd0 || flush_o !== 1'b0) begin miscompares++; $display("FAIL rm_state got count=%0d flush=%b want 0/0", q_count_o, flush_o); end
    vectors++; if (fetch_req_o !== 1'b1) begin miscompares++; $display("FAIL rm_run got %b want 1", fetch_req_o); end
    set_res(1, 0, 32'h0); tick(); set_res(0, 0, 0);
    vectors++; if (flush_o !== 1'b0 || pc_o !== 32'h0) begin miscompares++; $display("FAIL rm_noentry got flush=%b pc=%h want 0/00000000", flush_o, pc_o); end
  endtask

  initial begin
    test_reset();
    test_backward_branch();
    test_forward_mispredict();
    test_jalr();
    test_full_queue();
    test_simultaneous();
    test_empty_and_other();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
